// File: rtl/block_serializer.sv
// Reads WIDTH-bit blocks from an upstream FIFO and emits them MSB-first as a
// BYTE-wide valid/ready stream, counting completed blocks.
module block_serializer #(
  parameter int WIDTH = 64,
  parameter int BYTE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic [WIDTH-1:0] fifo_data,
  output logic [BYTE-1:0]  m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      blk_count,
  output logic [1:0]       fsm_state
);

  localparam int NB   = WIDTH / BYTE;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [IDXW-1:0]  idx;
  logic             xfer;

  // Stream handshake: a byte moves on any cycle where m_valid and m_ready are
  // both high; while m_ready is low in SEND, m_data/m_last/idx hold.
  assign m_data    = shreg[WIDTH-1 -: BYTE];
  assign xfer      = m_valid && m_ready;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    fifo_re    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        fifo_re = !fifo_empty;
        if (!fifo_empty) state_next = FETCH;
      end
      FETCH: state_next = SEND;
      SEND: begin
        m_valid = 1'b1;
        m_last  = (idx == LAST_IDX);
        // Chain straight into the next fetch so only one bubble separates blocks.
        if (m_ready && (idx == LAST_IDX)) begin
          fifo_re    = !fifo_empty;
          state_next = fifo_empty ? IDLE : FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset is synchronous, so the state may still be live during the reset
    // cycle; outputs are forced quiet so no word is popped or presented.
    if (rst) begin
      fifo_re = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      shreg     <= '0;
      blk_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: begin
          shreg <= fifo_data;
          idx   <= '0;
        end
        SEND: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              blk_count <= blk_count + 16'd1;
            end else begin
              shreg <= shreg << BYTE;
              idx   <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/block_serializer.md
BLOCK_SERIALIZER -- requirements
Module: block_serializer

Interface
REQ-001 Parameter WIDTH, default 64, width of one cipher block as read from the FIFO.
REQ-002 Parameter BYTE, default 8, width of the output stream; WIDTH SHALL be an integer multiple of BYTE (NB = WIDTH/BYTE, 8 by default).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream FIFO has no readable word.
REQ-006 fifo_re  output  1  read strobe to the upstream FIFO, one-cycle pulse per word.
REQ-007 fifo_data  input  WIDTH  FIFO read data, valid the cycle after fifo_re is asserted.
REQ-008 m_data  output  BYTE  output byte.
REQ-009 m_valid  output  1  m_data is valid.
REQ-010 m_ready  input  1  downstream accepts; a transfer occurs on a cycle with m_valid and m_ready both high.
REQ-011 m_last  output  1  current byte is the final byte of its block.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 blk_count  output  16  number of blocks fully transferred, modulo 2^16.

Function
REQ-014 The FSM SHALL have three states: IDLE, FETCH and SEND.
REQ-015 IDLE: fifo_re = !fifo_empty (combinational); if fifo_re, next state is FETCH, otherwise remain in IDLE.
REQ-016 FETCH: fifo_re = 0; capture fifo_data into the WIDTH-bit shift register, clear byte index to 0, go to SEND.
REQ-017 SEND: m_valid = 1; m_data = shift register [WIDTH-1 -: BYTE], so bytes go out MSB first.
REQ-018 SEND: m_last = 1 when byte index = NB-1, else 0.
REQ-019 SEND, transfer with index < NB-1: shift the register left by BYTE and increment the index.
REQ-020 SEND, transfer with index = NB-1: increment blk_count, wrapping 0xFFFF to 0x0000.
REQ-021 In the same case as REQ-020, if fifo_empty = 0 then assert fifo_re in that cycle and go to FETCH; otherwise go to IDLE.
REQ-022 SEND without a transfer: m_data, m_last, index and state SHALL hold unchanged.
REQ-023 fifo_re SHALL never be asserted while fifo_empty = 1, while rst = 1, in FETCH, or in SEND except as given in REQ-021.
REQ-024 At most one FIFO read SHALL be outstanding; every fifo_re pulse is followed by exactly one FETCH cycle.
REQ-025 Latency: fifo_re in cycle T gives the first m_valid in T+2; with m_ready held high, m_last occurs in T+2+NB-1.
REQ-026 Sustained throughput with m_ready high and the FIFO non-empty SHALL be one block per NB+1 cycles, with exactly one m_valid-low bubble (the FETCH cycle) between blocks.
REQ-027 Outside SEND, m_valid = 0 and m_last = 0; m_data is don't-care.

Reset
REQ-028 While rst = 1: state goes to IDLE, index = 0, shift register = 0, blk_count = 0, and fifo_re, m_valid, m_last and busy are all 0.
REQ-029 Reset in FETCH or mid-SEND SHALL discard the partial block without incrementing blk_count; the word already popped from the FIFO is lost.
REQ-030 The first block after reset SHALL begin at byte 0.

Verification
REQ-031 Reset with fifo_empty = 0 held for 2 cycles -> fifo_re = 0, m_valid = 0, busy = 0, blk_count = 0 throughout.
REQ-032 fifo_empty = 1 for 20 cycles -> fifo_re is never asserted; state stays IDLE.
REQ-033 One word 0x0A0B0C0D01020304, m_ready = 1, fifo_re at T -> m_valid from T+2 to T+9.
REQ-034 Same stimulus as REQ-033 -> bytes 0A 0B 0C 0D 01 02 03 04, m_last only on 04, blk_count = 1, FSM back in IDLE.
REQ-035 Words 0x000000000000000A and 0x0000000000000014 back-to-back, m_ready = 1 -> fifo_re pulses at T and T+9, 16 bytes out, one bubble at T+10, blk_count = 2.
REQ-036 m_ready alternating 1/0 starting at 0 -> m_data stable while stalled, 8 transfers in 16 cycles, order unchanged.
REQ-037 rst pulsed after 3 bytes are accepted -> m_valid = 0 the next cycle, blk_count = 0, and the next block starts with its MSB byte.
